// File: rtl/hamming_secded_decoder.sv
// Two-stage extended-Hamming (SECDED) decoder with valid/ready handshakes on
// both sides and saturating corrected/uncorrectable word counters.
package gray_area_package;
  function automatic int hamming_address_width(input int data_width);
    int p;
    int pow2;
    p = 0;
    for (int k = 1; k < 31; k++) begin
      pow2 = 32'sd1 <<< k;
      if ((p == 0) && (pow2 >= data_width + k + 1)) p = k;
    end
    return p;
  endfunction
endpackage

module hamming_secded_decoder #(
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH = 16,
  localparam int P = gray_area_package::hamming_address_width(DATA_WIDTH),
  localparam int CODE_WIDTH = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_WIDTH-1:0] in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [P-1:0]          out_syndrome,
  output logic                  out_corrected,
  output logic                  out_uncorrectable,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count
);
  localparam int LAST_POS = DATA_WIDTH + P;
  localparam logic [CODE_WIDTH-1:0] POS_ONE = {{(CODE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [P-1:0] calc_syndrome(input logic [CODE_WIDTH-1:0] code);
    logic [P-1:0] syn;
    syn = {P{1'b0}};
    for (int i = 1; i <= LAST_POS; i++) begin
      if (code[i]) syn = syn ^ P'(i);
    end
    return syn;
  endfunction

  function automatic logic calc_parity(input logic [CODE_WIDTH-1:0] code);
    return ^code;
  endfunction

  // Payload occupies every non-power-of-two position, LSB first.
  function automatic logic [DATA_WIDTH-1:0] extract_payload(input logic [CODE_WIDTH-1:0] code);
    logic [DATA_WIDTH-1:0] d;
    int j;
    d = {DATA_WIDTH{1'b0}};
    j = 0;
    for (int i = 1; i <= LAST_POS; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = code[i];
        j++;
      end
    end
    return d;
  endfunction

  logic                  s1_valid_r;
  logic [LAST_POS-1:0]   s1_word_r;
  logic [P-1:0]          s1_syndrome_r;
  logic                  s1_parity_r;
  logic                  out_en_s;
  logic                  s1_advance_s;
  logic                  out_fire_s;
  logic [DATA_WIDTH-1:0] fix_data_s;
  logic                  fix_corr_s;
  logic                  fix_unc_s;

  assign out_en_s     = !out_valid || out_ready;
  assign s1_advance_s = s1_valid_r && out_en_s;
  assign in_ready     = !s1_valid_r || s1_advance_s;
  assign out_fire_s   = out_valid && out_ready;

  // Stage 1: capture the word with its syndrome and overall parity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r    <= 1'b0;
      s1_word_r     <= {LAST_POS{1'b0}};
      s1_syndrome_r <= {P{1'b0}};
      s1_parity_r   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_word_r     <= in_code[CODE_WIDTH-1:1];
        s1_syndrome_r <= calc_syndrome(in_code);
        s1_parity_r   <= calc_parity(in_code);
      end
    end
  end

  // Classify the error and correct the payload when possible.
  always_comb begin
    fix_data_s = extract_payload({s1_word_r, 1'b0});
    fix_corr_s = 1'b0;
    fix_unc_s  = 1'b0;
    case ({(s1_syndrome_r != {P{1'b0}}), s1_parity_r})
      2'b00: fix_corr_s = 1'b0;
      2'b01: fix_corr_s = 1'b1;
      2'b10: fix_unc_s = 1'b1;
      2'b11: begin
        // Syndromes beyond the last position are aliases of the shortened code.
        if (32'(s1_syndrome_r) <= LAST_POS) begin
          fix_corr_s = 1'b1;
          fix_data_s = extract_payload({s1_word_r, 1'b0} ^ (POS_ONE << s1_syndrome_r));
        end else begin
          fix_unc_s = 1'b1;
        end
      end
      default: fix_unc_s = 1'b1;
    endcase
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= {DATA_WIDTH{1'b0}};
      out_syndrome      <= {P{1'b0}};
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (out_en_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data          <= fix_data_s;
        out_syndrome      <= s1_syndrome_r;
        out_corrected     <= fix_corr_s;
        out_uncorrectable <= fix_unc_s;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      corr_count   <= {CNT_WIDTH{1'b0}};
      uncorr_count <= {CNT_WIDTH{1'b0}};
    end else begin
      if (out_fire_s && out_corrected && (corr_count != CNT_MAX)) begin
        corr_count <= corr_count + CNT_ONE;
      end
      if (out_fire_s && out_uncorrectable && (uncorr_count != CNT_MAX)) begin
        uncorr_count <= uncorr_count + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized and directed bench for hamming_secded_decoder, checked against an
// error-injection reference model with an in-order scoreboard.
module tb_hamming_secded_decoder;
  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  syn;
    logic        corr;
    logic        unc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = 16'h0;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_valid, out_corrected, out_uncorrectable;
  logic [10:0] out_data;
  logic [3:0]  out_syndrome;
  logic [15:0] corr_count, uncorr_count;

  logic        in_ready2, out_valid2, out_corrected2, out_uncorrectable2;
  logic [10:0] out_data2;
  logic [3:0]  out_syndrome2;
  logic [1:0]  corr_count2, uncorr_count2;

  int n_assert = 0;
  int n_fail = 0;
  int m_corr = 0, m_unc = 0, m_corr2 = 0, m_unc2 = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hamming_secded_decoder #(.DATA_WIDTH(11), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable), .cnt_clear(cnt_clear),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  hamming_secded_decoder #(.DATA_WIDTH(11), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_syndrome(out_syndrome2), .out_corrected(out_corrected2),
    .out_uncorrectable(out_uncorrectable2), .cnt_clear(cnt_clear),
    .corr_count(corr_count2), .uncorr_count(uncorr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    logic b;
    c = 16'h0;
    j = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      b = 1'b0;
      for (int i = 1; i < 16; i++) if ((((i >> k) & 1) == 1) && c[i]) b = ~b;
      c[1 << k] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = 11'h0;
    j = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic exp_t mk_exp(input logic [10:0] d, input logic [3:0] s,
                                  input logic corr, input logic unc);
    exp_t e;
    e.data = d;
    e.syn  = s;
    e.corr = corr;
    e.unc  = unc;
    return e;
  endfunction

  // Random payload with 0, 1 or 2 flipped positions; expectation follows from what was injected.
  task automatic make_word(input int n_err, output logic [15:0] c, output exp_t e);
    logic [10:0] d;
    int a, b;
    d = 11'($urandom);
    a = $urandom_range(15);
    b = (a + 1 + $urandom_range(14)) % 16;
    c = encode(d);
    if (n_err == 0) begin
      e = mk_exp(d, 4'h0, 1'b0, 1'b0);
    end else if (n_err == 1) begin
      c = c ^ (16'd1 << a);
      e = mk_exp(d, 4'(a), 1'b1, 1'b0);
    end else begin
      c = c ^ (16'd1 << a) ^ (16'd1 << b);
      e = mk_exp(extract(c), 4'(a ^ b), 1'b0, 1'b1);
    end
  endtask

  // One clock: drive at the falling edge, judge handshakes just before the rising edge.
  task automatic step(input logic v, input logic [15:0] c, input exp_t e,
                      input logic ordy, input logic clr, output logic acc);
    logic a_in, a_out;
    exp_t f;
    in_valid = v;
    in_code = c;
    out_ready = ordy;
    cnt_clear = clr;
    #1;
    a_in = rst_n && in_valid && in_ready;
    a_out = rst_n && out_valid && out_ready;
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("stale_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_syndrome", 32'(out_syndrome), 32'(q[0].syn));
        chk("out_corrected", 32'(out_corrected), 32'(q[0].corr));
        chk("out_uncorrectable", 32'(out_uncorrectable), 32'(q[0].unc));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
    end else begin
      if (a_out && q.size() > 0) f = q.pop_front();
      else f = mk_exp(11'h0, 4'h0, 1'b0, 1'b0);
      if (clr) begin
        m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
      end else begin
        if (f.corr) begin
          if (m_corr < 65535) m_corr++;
          if (m_corr2 < 3) m_corr2++;
        end
        if (f.unc) begin
          if (m_unc < 65535) m_unc++;
          if (m_unc2 < 3) m_unc2++;
        end
      end
      if (a_in) q.push_back(e);
    end
    #1;
    chk("corr_count", 32'(corr_count), 32'(m_corr));
    chk("uncorr_count", 32'(uncorr_count), 32'(m_unc));
    chk("corr_count_w2", 32'(corr_count2), 32'(m_corr2));
    chk("uncorr_count_w2", 32'(uncorr_count2), 32'(m_unc2));
    @(negedge clk);
    acc = a_in;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    step(1'b0, 16'h0, mk_exp(11'h0, 4'h0, 1'b0, 1'b0), ordy, clr, acc);
  endtask

  task automatic send(input logic [15:0] c, input exp_t e, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) step(1'b1, c, e, ordy, 1'b0, acc);
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    logic [15:0] c;
    exp_t e;
    logic acc;
    logic [15:0] sv_c [4];
    exp_t sv_e [4];

    @(negedge clk);
    rst_n = 1'b0;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed vectors and two-cycle latency.
    send(16'hFFFF, mk_exp(11'h7FF, 4'h0, 1'b0, 1'b0), 1'b1);
    idle(1'b1, 1'b0);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    send(16'h0000, mk_exp(11'h000, 4'h0, 1'b0, 1'b0), 1'b1);
    send(16'hFFFF ^ 16'h0020, mk_exp(11'h7FF, 4'h5, 1'b1, 1'b0), 1'b1);
    send(16'h0001, mk_exp(11'h000, 4'h0, 1'b1, 1'b0), 1'b1);
    send(16'h0048, mk_exp(extract(16'h0048), 4'h5, 1'b0, 1'b1), 1'b1);
    repeat (3) idle(1'b1, 1'b0);
    chk("directed_corr_count", 32'(corr_count), 32'd2);
    chk("directed_uncorr_count", 32'(uncorr_count), 32'd1);

    // Backpressure: two accepts, then in_ready stalls while outputs hold.
    for (int i = 0; i < 4; i++) make_word(i % 3, sv_c[i], sv_e[i]);
    send(sv_c[0], sv_e[0], 1'b0);
    send(sv_c[1], sv_e[1], 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, sv_c[2], sv_e[2], 1'b0, 1'b0, acc);
      chk("stall_no_accept", 32'(acc), 32'd0);
    end
    send(sv_c[2], sv_e[2], 1'b1);
    send(sv_c[3], sv_e[3], 1'b1);
    repeat (3) idle(1'b1, 1'b0);
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Saturation of the narrow counter, then clear coinciding with a corrected transfer.
    for (int i = 0; i < 5; i++) begin
      make_word(1, c, e);
      send(c, e, 1'b1);
    end
    repeat (3) idle(1'b1, 1'b0);
    chk("sat_corr_count_w2", 32'(corr_count2), 32'd3);
    make_word(1, c, e);
    send(c, e, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("clear_corr_count", 32'(corr_count), 32'd0);
    chk("clear_corr_count_w2", 32'(corr_count2), 32'd0);

    // Random traffic with random valid gaps, backpressure and occasional clears.
    for (int n = 0; n < 80; n++) begin
      make_word($urandom_range(2), c, e);
      acc = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        if ($urandom_range(3) == 0) idle($urandom_range(3) != 0, $urandom_range(19) == 0);
        else step(1'b1, c, e, $urandom_range(3) != 0, $urandom_range(19) == 0, acc);
      end
      chk("random_accepted", 32'(acc), 32'd1);
    end
    repeat (4) idle(1'b1, 1'b0);
    chk("random_drained", 32'(q.size()), 32'd0);

    // Reset with two words in flight: both discarded and never counted.
    make_word(1, c, e);
    send(c, e, 1'b1);
    repeat (3) idle(1'b1, 1'b0);
    make_word(1, c, e);
    send(c, e, 1'b0);
    make_word(2, c, e);
    send(c, e, 1'b0);
    rst_n = 1'b0;
    idle(1'b1, 1'b0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_corr_count", 32'(corr_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, 1'b0);
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001: The module SHALL have parameter DATA_WIDTH, default 11, giving the number of decoded payload bits (minimum 4).
REQ-002: The module SHALL have derived localparam P, equal to gray_area_package::hamming_address_width(DATA_WIDTH), giving the number of Hamming check bits.
REQ-003: The module SHALL have derived localparam CODE_WIDTH, equal to DATA_WIDTH+P+1, giving the extended-code word width.
REQ-004: The module SHALL have parameter CNT_WIDTH, default 16, giving the width of each error counter.
REQ-005: clk  input  1  sole clock; all state updates on rising edge.
REQ-006: rst_n  input  1  reset, synchronous, active-low.
REQ-007: in_valid  input  1  code word on in_code is valid.
REQ-008: in_ready  output  1  decoder accepts in_code this cycle.
REQ-009: in_code  input  CODE_WIDTH  received extended Hamming code word.
REQ-010: out_valid  output  1  decoded result is valid.
REQ-011: out_ready  input  1  downstream accepts the result.
REQ-012: out_data  output  DATA_WIDTH  corrected payload.
REQ-013: out_syndrome  output  P  Hamming syndrome of the word.
REQ-014: out_corrected  output  1  single-bit error was corrected.
REQ-015: out_uncorrectable  output  1  error was detected but not correctable.
REQ-016: cnt_clear  input  1  synchronous clear of both error counters.
REQ-017: corr_count  output  CNT_WIDTH  saturating count of corrected words.
REQ-018: uncorr_count  output  CNT_WIDTH  saturating count of uncorrectable words.

Function
REQ-019: Code layout SHALL be as follows: in_code[i] is code position i; position 0 holds overall even parity; positions 2^k (k=0..P-1) hold check bits; the remaining positions 1..DATA_WIDTH+P hold payload bits in ascending order, payload LSB at the lowest position.
REQ-020: Syndrome SHALL be the P-bit XOR of the indices of all set positions 1..DATA_WIDTH+P; overall parity SHALL be the XOR of all CODE_WIDTH bits.
REQ-021: The decoder SHALL be a two-stage pipeline (S1: syndrome plus overall parity registered with the word; S2: correction plus flags registered to the outputs), giving a latency of 2 cycles from acceptance to out_valid with no stalls.
REQ-022: A transfer SHALL occur on each interface when its valid and ready are both high in the same cycle.
REQ-023: Output registers SHALL update only when !out_valid || out_ready.
REQ-024: S1 SHALL advance only when S2 can accept.
REQ-025: in_ready SHALL equal !s1_valid || s1_advance (combinational).
REQ-026: Full throughput of 1 word per cycle SHALL be sustained while out_ready=1.
REQ-027: out_* SHALL hold stable while out_valid && !out_ready.
REQ-028: Syndrome 0 with parity 0 SHALL be clean: both flags 0 and payload passed through.
REQ-029: Syndrome s!=0 with parity 1 and s<=DATA_WIDTH+P SHALL flip position s, set out_corrected=1 and extract the payload.
REQ-030: Syndrome s!=0 with parity 1 and s>DATA_WIDTH+P (shortened-code alias) SHALL set out_uncorrectable=1 and pass the payload uncorrected.
REQ-031: Syndrome 0 with parity 1 SHALL be treated as a position-0 error: out_corrected=1 and payload unchanged.
REQ-032: Syndrome !=0 with parity 0 SHALL be a double error: out_uncorrectable=1 and payload passed uncorrected.
REQ-033: out_corrected and out_uncorrectable SHALL never both be 1.
REQ-034: Counters SHALL increment by 1 on each output transfer whose corresponding flag is set and SHALL saturate at all-ones (no wrap).
REQ-035: cnt_clear SHALL zero both counters and SHALL override a simultaneous increment.

Reset
REQ-036: While rst_n=0 at a clock edge, s1_valid and out_valid SHALL go to 0, out_data, out_syndrome and both flags SHALL go to 0, and both counters SHALL go to 0.
REQ-037: in_ready SHALL be 1 during the cycle following reset deassertion.
REQ-038: Words in flight when reset is asserted mid-operation SHALL be discarded and SHALL NOT be counted.

Verification (DATA_WIDTH=11, CODE_WIDTH=16)
REQ-039: Input 16'hFFFF with out_ready=1 SHALL produce, 2 cycles later, out_data=11'h7FF, syndrome 0 and both flags 0; input 16'h0000 SHALL produce out_data=0 and both flags 0.
REQ-040: Input 16'hFFFF^16'h0020 SHALL produce out_data=11'h7FF, out_syndrome=5, out_corrected=1 and corr_count=1; input 16'h0001 SHALL produce out_data=0, syndrome 0, out_corrected=1.
REQ-041: Input 16'h0048 (bits 3 and 6 set) SHALL produce out_syndrome=5, out_uncorrectable=1 and uncorr_count incremented.
REQ-042: A stream of 4 back-to-back words with out_ready held 0 for 3 cycles SHALL stall in_ready after 2 accepts, hold outputs stable, and deliver all 4 in order with none lost or duplicated.
REQ-043: With CNT_WIDTH=2, 5 single-error words SHALL leave corr_count=3; cnt_clear asserted on the cycle of a further corrected transfer SHALL yield corr_count=0.
REQ-044: rst_n=0 asserted with 2 words in flight SHALL give out_valid=0 and counters 0 the following cycle, and no stale word SHALL appear after release.
